// File: rtl/pulse_divider.sv
// Rising-edge pulse divider: one registered output pulse per `divisor` input edges.
// Optional two-flop input synchroniser enabled by defining PULSE_DIVIDER_SYNC_EN.
module pulse_divider #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inputPulse,
    input  logic             enable,
    input  logic             divLoad,
    input  logic [WIDTH-1:0] divValue,
    input  logic             oneShot,
    output logic             outputPulse,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic             cur_c;
    logic             edge_c;
    logic             armed_c;
    logic             prev_q;
    logic [1:0]       arm_cnt_q;
    logic [WIDTH-1:0] div_q,   div_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             out_q,   out_d;
    logic             done_q,  done_d;

`ifdef PULSE_DIVIDER_SYNC_EN
    // Edges are ignored until prev_q holds a genuine post-reset sample (3 stages deep).
    localparam int unsigned ARM_CYCLES = 3;

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= inputPulse;
            sync2_q <= sync1_q;
        end
    end

    assign cur_c = sync2_q;
`else
    localparam int unsigned ARM_CYCLES = 1;

    assign cur_c = inputPulse;
`endif

    // Previous-sample flop and post-reset arming counter for the edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q    <= 1'b0;
            arm_cnt_q <= 2'd0;
        end else begin
            prev_q <= cur_c;
            if (arm_cnt_q != 2'(ARM_CYCLES)) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end
        end
    end

    assign armed_c = (arm_cnt_q == 2'(ARM_CYCLES));
    assign edge_c  = cur_c & ~prev_q & armed_c;

    // Divider next state: a valid load beats any coincident edge.
    always_comb begin
        div_d   = div_q;
        count_d = count_q;
        done_d  = done_q;
        out_d   = 1'b0;
        if (divLoad && (divValue != '0)) begin
            div_d   = divValue;
            count_d = '0;
            done_d  = 1'b0;
        end else begin
            if (!oneShot) begin
                done_d = 1'b0;
            end
            if (edge_c && enable && !done_q) begin
                if (count_q == (div_q - WIDTH'(1))) begin
                    count_d = '0;
                    out_d   = 1'b1;
                    if (oneShot) begin
                        done_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= WIDTH'(DEFAULT_DIV);
            count_q <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            count_q <= count_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign outputPulse = out_q;
    assign count       = count_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pulse_divider.sv
// Scoreboard bench for pulse_divider: expected pulse edge numbers are queued as
// edges are driven and popped when outputPulse is observed.
module tb_pulse_divider;

`ifdef PULSE_DIVIDER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst;
    logic       inputPulse;
    logic       enable;
    logic       divLoad;
    logic [7:0] divValue;
    logic       oneShot;
    logic       outputPulse;
    logic [7:0] count;
    logic       done;

    int checks;
    int passes;
    int edge_no;
    int pulse_total;
    int m_div;
    int m_count;
    bit m_done;
    int exp_q[$];

    pulse_divider #(.WIDTH(8), .DEFAULT_DIV(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .inputPulse (inputPulse),
        .enable     (enable),
        .divLoad    (divLoad),
        .divValue   (divValue),
        .oneShot    (oneShot),
        .outputPulse(outputPulse),
        .count      (count),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_div   = 100;
        m_count = 0;
        m_done  = 1'b0;
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        divLoad  = 1'b1;
        divValue = 8'(v);
        @(negedge clk);
        divLoad  = 1'b0;
        divValue = 8'd0;
        if (v != 0) begin
            m_div   = v;
            m_count = 0;
            m_done  = 1'b0;
        end
    endtask

    // Drive n input edges; model predicts pulses, observed pulses are popped and compared.
    task automatic run_edges(input int n);
        int pulses;
        int exp;
        for (int i = 0; i < n; i++) begin
            edge_no++;
            @(negedge clk);
            inputPulse = 1'b1;
            if (enable && !m_done) begin
                if (m_count == m_div - 1) begin
                    m_count = 0;
                    exp_q.push_back(edge_no);
                    if (oneShot) m_done = 1'b1;
                end else begin
                    m_count++;
                end
            end
            pulses = 0;
            repeat (4) begin
                @(negedge clk);
                if (outputPulse === 1'b1) pulses++;
            end
            inputPulse = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (outputPulse === 1'b1) pulses++;
            end
            pulse_total += pulses;
            if (pulses != 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pulse_unexpected: pulse at edge %0d, none expected", edge_no);
                end else begin
                    exp = exp_q.pop_front();
                    if (pulses != 1 || exp != edge_no)
                        $display("FAIL pulse_edge: %0d pulse(s) at edge %0d, expected 1 at edge %0d",
                                 pulses, edge_no, exp);
                    else
                        passes++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; inputPulse = 1'b0; enable = 1'b1; divLoad = 1'b0;
        divValue = 8'd0; oneShot = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", count); else passes++;
        checks++; if (outputPulse !== 1'b0) $display("FAIL reset_pulse: got %b expected 0", outputPulse); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
    endtask

    task automatic test_continuous();
        edge_no = 0; pulse_total = 0; exp_q.delete();
        run_edges(250);
        checks++; if (pulse_total != 2) $display("FAIL cont_pulses: got %0d expected 2", pulse_total); else passes++;
        checks++; if (count !== 8'd50) $display("FAIL cont_count: got %0d expected 50", count); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL cont_missing: %0d pulse(s) not seen expected 0", exp_q.size()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_runtime_load();
        edge_no = 0; pulse_total = 0; exp_q.delete();
        do_load(3);
        checks++; if (count !== 8'd0) $display("FAIL load_clear: got %0d expected 0", count); else passes++;
        run_edges(7);
        checks++; if (count !== 8'd1) $display("FAIL load_count7: got %0d expected 1", count); else passes++;
        do_load(0);
        checks++; if (count !== 8'd1) $display("FAIL load_zero: got %0d expected 1", count); else passes++;
        run_edges(2);
        checks++; if (pulse_total != 3) $display("FAIL load_div_kept: got %0d pulses expected 3", pulse_total); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL load_missing: %0d pulse(s) not seen expected 0", exp_q.size()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_oneshot();
        edge_no = 0; pulse_total = 0; exp_q.delete();
        oneShot = 1'b1;
        do_load(4);
        run_edges(10);
        checks++; if (pulse_total != 1) $display("FAIL os_pulses: got %0d expected 1", pulse_total); else passes++;
        checks++; if (done !== 1'b1) $display("FAIL os_done: got %b expected 1", done); else passes++;
        checks++; if (count !== 8'd0) $display("FAIL os_count: got %0d expected 0", count); else passes++;
        do_load(4);
        checks++; if (done !== 1'b0) $display("FAIL os_reload_done: got %b expected 0", done); else passes++;
        run_edges(4);
        checks++; if (done !== 1'b1) $display("FAIL os_done2: got %b expected 1", done); else passes++;
        oneShot = 1'b0;
        m_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL os_clear: got %b expected 0", done); else passes++;
        run_edges(1);
        checks++; if (count !== 8'd1) $display("FAIL os_resume: got %0d expected 1", count); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL os_missing: %0d pulse(s) not seen expected 0", exp_q.size()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_collision_enable();
        edge_no = 0; exp_q.delete();
        do_load(5);
        @(negedge clk);
        inputPulse = 1'b1;
        repeat (LAT) @(negedge clk);
        divLoad = 1'b1; divValue = 8'd5;
        @(negedge clk);
        divLoad = 1'b0; divValue = 8'd0;
        m_div = 5; m_count = 0;
        repeat (4) @(negedge clk);
        checks++; if (count !== 8'd0) $display("FAIL collide_count: got %0d expected 0", count); else passes++;
        inputPulse = 1'b0;
        repeat (4) @(negedge clk);
        run_edges(2);
        checks++; if (count !== 8'd2) $display("FAIL en_pre: got %0d expected 2", count); else passes++;
        enable = 1'b0;
        run_edges(5);
        checks++; if (count !== 8'd2) $display("FAIL en_hold: got %0d expected 2", count); else passes++;
        inputPulse = 1'b1;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (count !== 8'(m_count)) $display("FAIL en_rise_high: got %0d expected %0d", count, m_count); else passes++;
        inputPulse = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (exp_q.size() != 0) $display("FAIL ce_missing: %0d pulse(s) not seen expected 0", exp_q.size()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        edge_no = 0; pulse_total = 0; exp_q.delete();
        do_load(100);
        run_edges(37);
        checks++; if (count !== 8'd37) $display("FAIL rm_pre: got %0d expected 37", count); else passes++;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (count !== 8'd0) $display("FAIL rm_async_count: got %0d expected 0", count); else passes++;
        checks++; if (outputPulse !== 1'b0) $display("FAIL rm_async_pulse: got %b expected 0", outputPulse); else passes++;
        model_reset();
        inputPulse = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (count !== 8'd0) $display("FAIL rm_high_release: got %0d expected 0", count); else passes++;
        inputPulse = 1'b0;
        repeat (4) @(negedge clk);
        edge_no = 0;
        run_edges(100);
        checks++; if (pulse_total != 1) $display("FAIL rm_default_div: got %0d pulses expected 1", pulse_total); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL rm_missing: %0d pulse(s) not seen expected 0", exp_q.size()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_div1_latency();
        int lat;
        edge_no = 0; pulse_total = 0; exp_q.delete();
        do_load(1);
        run_edges(5);
        checks++; if (pulse_total != 5) $display("FAIL div1_pulses: got %0d expected 5", pulse_total); else passes++;
        checks++; if (count !== 8'd0) $display("FAIL div1_count: got %0d expected 0", count); else passes++;
        lat = 0;
        @(negedge clk);
        inputPulse = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (outputPulse === 1'b1 && lat == 0) lat = k;
        end
        inputPulse = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (lat != 1 + LAT) $display("FAIL latency: got %0d cycles expected %0d", lat, 1 + LAT); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL div1_missing: %0d pulse(s) not seen expected 0", exp_q.size()); else passes++;
        exp_q.delete();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        edge_no = 0;
        pulse_total = 0;
        test_reset();
        test_continuous();
        test_runtime_load();
        test_oneshot();
        test_collision_enable();
        test_reset_mid();
        test_div1_latency();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
